// File: rtl/afe_seq_pkg.sv
// afe_seq_pkg
// Shared types and constants for the AFE readout sequencer.
//   seq_state_t  : sequencer state encoding
//   AXIS_WORDS   : words per aggregator axis
//   FRAME_WORDS  : words per streamed frame (y-axis followed by x-axis)
//   IDX_W/DATA_W : aggregator read-index and data widths
//   WORD_W       : width of the in-frame word counter
//   WDOG_W       : width of the WAIT_FIN watchdog counter
package afe_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_CONV,
    ST_WAIT_FIN,
    ST_STREAM
  } seq_state_t;

  localparam int AXIS_WORDS  = 128;
  localparam int FRAME_WORDS = 256;
  localparam int IDX_W       = 7;
  localparam int DATA_W      = 16;
  localparam int WORD_W      = 8;
  localparam int WDOG_W      = 20;

endpackage

// File: rtl/afe_readout_sequencer_watchdog.sv
// readout_watchdog
// Loadable down-counter that flags when the sequencer has waited too long
// for the aggregator.
//   clk, reset  : clock, asynchronous active-high reset
//   clear       : zero the counter (highest priority)
//   load        : load load_value
//   load_value  : reload value (number of enabled cycles minus one)
//   enable      : count down while high
//   expire      : high during the enabled cycle in which the count is zero
module readout_watchdog
  import afe_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic [WDOG_W-1:0] load_value,
  input  logic              enable,
  output logic              expire
);

  logic [WDOG_W-1:0] count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (enable && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  // Counter stops at zero; expire is a pulse for as long as the owner keeps
  // enable high, which the sequencer drops by leaving WAIT_FIN.
  assign expire = enable && (count_reg == '0);

endmodule

// File: rtl/afe_readout_sequencer.sv
// afe_readout_sequencer
// Frame-level controller for data_aggregator: clears the aggregator, pulses
// the AFE conversion trigger, waits for the aggregator to finish, then streams
// y[0..127] followed by x[0..127] over a valid/ready interface.
// Ports:
//   clk, reset                : clock, asynchronous active-high reset
//   start, abort              : frame request (IDLE only), return-to-IDLE
//   busy                      : high outside IDLE
//   agg_clear, afe_conv       : aggregator synchronous reset, AFE trigger
//   agg_finished              : aggregator finished flag
//   read_index_yaxis/xaxis    : aggregator read indices
//   agg_data_yaxis/xaxis      : aggregator read data
//   m_data, m_valid, m_ready, m_last : output stream
//   frame_count               : completed frames, wrapping
//   timeout_err               : sticky watchdog flag
// Compile-time option: define READOUT_TIMEOUT_EN to build the WAIT_FIN
// watchdog (TIMEOUT_CYCLES); otherwise WAIT_FIN waits forever and
// timeout_err is tied low.
module afe_readout_sequencer
  import afe_seq_pkg::*;
#(
  parameter int unsigned CONV_PULSE_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES    = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              agg_clear,
  output logic              afe_conv,
  input  logic              agg_finished,
  output logic [IDX_W-1:0]  read_index_yaxis,
  output logic [IDX_W-1:0]  read_index_xaxis,
  input  logic [DATA_W-1:0] agg_data_yaxis,
  input  logic [DATA_W-1:0] agg_data_xaxis,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic [15:0]       frame_count,
  output logic              timeout_err
);

  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(FRAME_WORDS - 1);
  localparam logic [7:0]        CONV_LOAD = 8'(CONV_PULSE_CYCLES - 1);

  seq_state_t        state_reg;
  logic [WORD_W-1:0] word_reg;
  logic [7:0]        conv_cnt_reg;
  logic              busy_reg;
  logic              agg_clear_reg;
  logic              afe_conv_reg;
  logic              m_valid_reg;
  logic              m_last_reg;
  logic [15:0]       frame_count_reg;
  logic              in_stream;

`ifdef READOUT_TIMEOUT_EN
  logic wd_expire;
  logic timeout_err_reg;

  // Reloaded on every CONV cycle so the count is fresh on entry to WAIT_FIN.
  readout_watchdog u_watchdog (
    .clk        (clk),
    .reset      (reset),
    .clear      (abort),
    .load       (state_reg == ST_CONV),
    .load_value (WDOG_W'(TIMEOUT_CYCLES - 1)),
    .enable     (state_reg == ST_WAIT_FIN),
    .expire     (wd_expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout_err_reg <= 1'b0;
    end else if (!abort) begin
      if ((state_reg == ST_IDLE) && start) begin
        timeout_err_reg <= 1'b0;
      end else if ((state_reg == ST_WAIT_FIN) && !agg_finished && wd_expire) begin
        timeout_err_reg <= 1'b1;
      end
    end
  end

  assign timeout_err = timeout_err_reg;
`else
  logic [WDOG_W-1:0] unused_timeout_cycles;
  assign unused_timeout_cycles = WDOG_W'(TIMEOUT_CYCLES);
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      word_reg        <= '0;
      conv_cnt_reg    <= '0;
      busy_reg        <= 1'b0;
      agg_clear_reg   <= 1'b0;
      afe_conv_reg    <= 1'b0;
      m_valid_reg     <= 1'b0;
      m_last_reg      <= 1'b0;
      frame_count_reg <= '0;
    end else if (abort) begin
      // Truncates any frame in flight; frame_count only counts complete frames.
      state_reg     <= ST_IDLE;
      word_reg      <= '0;
      busy_reg      <= 1'b0;
      agg_clear_reg <= 1'b0;
      afe_conv_reg  <= 1'b0;
      m_valid_reg   <= 1'b0;
      m_last_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg     <= ST_CLEAR;
            busy_reg      <= 1'b1;
            agg_clear_reg <= 1'b1;
          end
        end
        ST_CLEAR: begin
          state_reg     <= ST_CONV;
          agg_clear_reg <= 1'b0;
          afe_conv_reg  <= 1'b1;
          conv_cnt_reg  <= CONV_LOAD;
        end
        ST_CONV: begin
          if (conv_cnt_reg == '0) begin
            state_reg    <= ST_WAIT_FIN;
            afe_conv_reg <= 1'b0;
          end else begin
            conv_cnt_reg <= conv_cnt_reg - 1'b1;
          end
        end
        ST_WAIT_FIN: begin
          // finished is only trusted here: the aggregator was cleared first.
          if (agg_finished) begin
            state_reg   <= ST_STREAM;
            word_reg    <= '0;
            m_valid_reg <= 1'b1;
            m_last_reg  <= 1'b0;
          end
`ifdef READOUT_TIMEOUT_EN
          else if (wd_expire) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end
`endif
        end
        ST_STREAM: begin
          if (m_ready) begin
            if (word_reg == LAST_WORD) begin
              state_reg       <= ST_IDLE;
              word_reg        <= '0;
              busy_reg        <= 1'b0;
              m_valid_reg     <= 1'b0;
              m_last_reg      <= 1'b0;
              frame_count_reg <= frame_count_reg + 1'b1;
            end else begin
              word_reg   <= word_reg + 1'b1;
              // m_last is registered, so raise it as the counter steps onto 255.
              m_last_reg <= (word_reg == (LAST_WORD - 1'b1));
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_stream = (state_reg == ST_STREAM);

  assign read_index_yaxis = in_stream ? word_reg[IDX_W-1:0] : '0;
  assign read_index_xaxis = in_stream ? word_reg[IDX_W-1:0] : '0;

  // Word counter MSB picks the axis: 0..127 y-axis, 128..255 x-axis.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_data_mux
      assign m_data[gi] = in_stream &
                          (word_reg[IDX_W] ? agg_data_xaxis[gi] : agg_data_yaxis[gi]);
    end
  endgenerate

  assign busy        = busy_reg;
  assign agg_clear   = agg_clear_reg;
  assign afe_conv    = afe_conv_reg;
  assign m_valid     = m_valid_reg;
  assign m_last      = m_last_reg;
  assign frame_count = frame_count_reg;

endmodule

// File: doc/afe_readout_sequencer.md
# afe_readout_sequencer

Frame-level controller for `data_aggregator`. On a start request it clears the aggregator, pulses the AFE conversion trigger and waits for the aggregator's `finished`. It then drives the aggregator read indices to stream all 256 words to the host interface over a valid/ready handshake: y-axis 0..127, then x-axis 0..127. It sits between the host/USB framing logic and the aggregator, and is the only driver of the aggregator's reset and read ports.

## Interface
Parameters:
- `CONV_PULSE_CYCLES`, default 4: width of the `afe_conv` pulse in clk cycles; legal range 1..255.
- `TIMEOUT_CYCLES`, default 65535: maximum number of cycles spent in WAIT_FIN, only used when the watchdog is compiled in; legal range 1..2^20-1.

Ports:
- `clk`  in  1  single clock for the block.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  frame request, sampled only in IDLE.
- `abort`  in  1  forces a return to IDLE from any state.
- `busy`  out  1  high in every state except IDLE.
- `agg_clear`  out  1  drives the aggregator's synchronous `reset`.
- `afe_conv`  out  1  AFE conversion trigger.
- `agg_finished`  in  1  aggregator `finished`.
- `read_index_yaxis`  out  7  aggregator y read index.
- `read_index_xaxis`  out  7  aggregator x read index.
- `agg_data_yaxis`  in  16  aggregator `out_data_yaxis`.
- `agg_data_xaxis`  in  16  aggregator `out_data_xaxis`.
- `m_data`  out  16  stream data.
- `m_valid`  out  1  stream valid.
- `m_ready`  in  1  stream ready.
- `m_last`  out  1  high on word 255 of the frame.
- `frame_count`  out  16  count of completed frames; wraps from 0xFFFF to 0.
- `timeout_err`  out  1  sticky watchdog flag.

## Operation
States: IDLE, CLEAR, CONV, WAIT_FIN, STREAM.
- IDLE: if `start` is high, go to CLEAR and clear `timeout_err`.
- CLEAR: lasts 1 cycle with `agg_clear`=1, then go to CONV.
- CONV: lasts `CONV_PULSE_CYCLES` cycles with `afe_conv`=1, then go to WAIT_FIN.
- WAIT_FIN: when `agg_finished` is high, go to STREAM with the 8-bit word counter w=0. `agg_finished` is ignored in every other state, because stale flags are only guaranteed cleared after CLEAR.
- STREAM:
  - `read_index_yaxis` = `read_index_xaxis` = w[6:0].
  - `m_data` = w[7] ? `agg_data_xaxis` : `agg_data_yaxis`. This path is combinational; aggregator data is stable while in STREAM.
  - `m_valid`=1.
  - `m_last` = (w==255).
  - On `m_valid`&&`m_ready`: w increments.
  - On the handshake with w==255: go to IDLE and increment `frame_count`.
- `abort` has priority over every transition: the next state is IDLE, `m_valid` drops and `frame_count` is unchanged. A mid-frame abort truncates the packet without `m_last`; the host framer must tolerate this.
- `start` outside IDLE is ignored and is not queued.
- Outside STREAM the read indices are 0, and `m_data` is 0.
- Output reset values: `busy`=0, `agg_clear`=0, `afe_conv`=0, both indices 0, `m_data`=0, `m_valid`=0, `m_last`=0, `frame_count`=0, `timeout_err`=0.
- All state, counter and flag outputs are registered. `m_data` and the read indices are decoded from registered state and the w counter.

## Timing
- `start` high at edge N (in IDLE): `agg_clear`=1 during cycle N+1.
- `afe_conv`=1 during cycles N+2 .. N+1+`CONV_PULSE_CYCLES`.
- WAIT_FIN begins at cycle N+2+`CONV_PULSE_CYCLES`.
- `agg_finished` sampled high at edge M: `m_valid`=1 from cycle M+1.
- With `m_ready` held high, one word transfers per cycle, so the 256 words occupy cycles M+1..M+256.
- `busy` falls and `frame_count` updates in cycle M+257.
- Back-to-back frames: the earliest the next `start` can be accepted is the first IDLE cycle, so there is at least one idle cycle between frames.

## Configuration
- `READOUT_TIMEOUT_EN` defined:
  - A 20-bit watchdog counts cycles in WAIT_FIN.
  - When the count reaches `TIMEOUT_CYCLES` without `agg_finished`, the next state is IDLE, `timeout_err` is set and `frame_count` is unchanged.
- `READOUT_TIMEOUT_EN` undefined: WAIT_FIN waits indefinitely (only `abort` exits), `timeout_err` is tied to 0, and no watchdog logic is generated.

## Structure
- Package `afe_seq_pkg` contains:
  - the state enum;
  - `AXIS_WORDS`=128;
  - `FRAME_WORDS`=256;
  - `IDX_W`=7;
  - `DATA_W`=16.
- One sub-module, `readout_watchdog`: a loadable down-counter with a clear and an expire pulse. It is instantiated only under `READOUT_TIMEOUT_EN`.

## Test plan
- Reset is asserted asynchronously mid-STREAM. Required: all outputs return to their reset values immediately; after release the state is IDLE and `frame_count`=0.
- Nominal frame: `start` pulse, aggregator model asserts `finished` 300 cycles after `afe_conv`, `m_ready`=1. Required:
  - exactly 256 words, matching y[0..127] then x[0..127];
  - `m_last` only on word 255;
  - `frame_count`=1.
- Backpressure: `m_ready` toggles with a random 50% duty. Required: no word is dropped or duplicated, and `m_data` is stable while `m_valid`&&!`m_ready`.
- `abort` asserted at word 100. Required: `m_valid`=0 on the next cycle, state is IDLE and `frame_count` is unchanged. A following frame streams all 256 words correctly.
- `start` held high continuously with `agg_finished` stuck at 1 from a previous frame. Required: `finished` is ignored during CLEAR and CONV, and consecutive frames are separated by at least one IDLE cycle.
- With `READOUT_TIMEOUT_EN` and `TIMEOUT_CYCLES`=50, `agg_finished` is never asserted. Required: `timeout_err`=1 and IDLE after 50 cycles of WAIT_FIN. The next accepted `start` clears `timeout_err`.
